// File: rtl/audiosystem_debug_scan_pkg.sv
// Shared definitions for the virtual-JTAG scan master and the CPU debug slave:
// scan FSM state encoding, default scan widths and the 2-bit virtual IR codes.
package audiosystem_debug_scan_pkg;

    localparam int DR_W = 38;
    localparam int IR_W = 2;

    // Virtual IR codes understood by the debug slave
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACE     = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UIR   = 3'd1,
        ST_CDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_UDR   = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

endpackage

// File: rtl/audiosystem_debug_scan_tckgen.sv
// Scan clock generator: divides clk down to tck (TCK_DIV clk cycles per
// half-period) and provides single-cycle enables marking the clk edge on
// which tck rises or falls.
module audiosystem_debug_scan_tckgen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);
    localparam int CNT_W = $clog2(TCK_DIV);

    logic [CNT_W-1:0] cnt_reg;
    logic             tck_reg;
    logic             tick;

    assign tick     = (cnt_reg == CNT_W'(TCK_DIV - 1));
    assign tck_rise = tick && !tck_reg;
    assign tck_fall = tick && tck_reg;
    assign tck      = tck_reg;

    // Half-period counter; tck toggles when the counter wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg <= '0;
            tck_reg <= ~tck_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audiosystem_debug_scan_master.sv
// Host-side virtual-JTAG scan initiator. Serialises IR-load and DR-scan
// commands into tck/tdi plus cdr/sdr/udr/uir/rti strobes and returns the
// captured tdo (or IR readback) bits as a response.
// Optional build macro SCAN_COUNT_EN adds a saturating completed-DR-scan
// counter on output scan_count.
module audiosystem_debug_scan_master #(
    parameter int TCK_DIV = 4,
    parameter int DR_W    = 38,
    parameter int IR_W    = 2,
    parameter int LEN_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_is_ir,
    input  logic [IR_W-1:0]  cmd_ir,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [DR_W-1:0]  cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DR_W-1:0]  rsp_data,
    output logic             vji_tck,
    output logic             vji_tdi,
    input  logic             vji_tdo,
    output logic [IR_W-1:0]  vji_ir_in,
    input  logic [IR_W-1:0]  vji_ir_out,
    output logic             vji_cdr,
    output logic             vji_sdr,
    output logic             vji_udr,
    output logic             vji_uir,
    output logic             vji_rti
`ifdef SCAN_COUNT_EN
    ,
    output logic [15:0]      scan_count
`endif
);
    import audiosystem_debug_scan_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DR_W);

    scan_state_t      state_reg;
    logic             pending_reg;
    logic             is_ir_reg;
    logic [IR_W-1:0]  ir_val_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] bit_idx_reg;
    logic [DR_W-1:0]  sr_reg;
    logic [DR_W-1:0]  cap_reg;
    logic             rsp_valid_reg;
    logic             tdi_reg;
    logic [IR_W-1:0]  ir_in_reg;
    logic             cdr_reg, sdr_reg, udr_reg, uir_reg, rti_reg;
    logic             tck_rise, tck_fall;

    audiosystem_debug_scan_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
        .clk      (clk),
        .rst      (reset),
        .tck      (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // pending_reg covers the gap between accept and the next tck fall
    assign cmd_ready = (state_reg == ST_IDLE) && !rsp_valid_reg && !pending_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = cap_reg;
    assign vji_tdi   = tdi_reg;
    assign vji_ir_in = ir_in_reg;
    assign vji_cdr   = cdr_reg;
    assign vji_sdr   = sdr_reg;
    assign vji_udr   = udr_reg;
    assign vji_uir   = uir_reg;
    assign vji_rti   = rti_reg;

    // Command latch and scan sequencer; all vji outputs move only on tck_fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= 1'b0;
            is_ir_reg     <= 1'b0;
            ir_val_reg    <= '0;
            len_reg       <= '0;
            bit_idx_reg   <= '0;
            sr_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            tdi_reg       <= 1'b0;
            ir_in_reg     <= '0;
            cdr_reg       <= 1'b0;
            sdr_reg       <= 1'b0;
            udr_reg       <= 1'b0;
            uir_reg       <= 1'b0;
            rti_reg       <= 1'b1;
        end else begin
            if (cmd_valid && cmd_ready) begin
                pending_reg <= 1'b1;
                is_ir_reg   <= cmd_is_ir;
                ir_val_reg  <= cmd_ir;
                len_reg     <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                sr_reg      <= cmd_data;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (tck_fall) begin
                        if (pending_reg) begin
                            pending_reg <= 1'b0;
                            rti_reg     <= 1'b0;
                            if (is_ir_reg) begin
                                state_reg <= ST_UIR;
                                uir_reg   <= 1'b1;
                                ir_in_reg <= ir_val_reg;
                            end else begin
                                state_reg <= ST_CDR;
                                cdr_reg   <= 1'b1;
                            end
                        end else begin
                            rti_reg <= 1'b1;
                        end
                    end
                end
                ST_UIR: begin
                    if (tck_fall) begin
                        uir_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_CDR: begin
                    if (tck_fall) begin
                        cdr_reg     <= 1'b0;
                        bit_idx_reg <= '0;
                        if (len_reg == '0) begin
                            udr_reg   <= 1'b1;
                            state_reg <= ST_UDR;
                        end else begin
                            sdr_reg   <= 1'b1;
                            tdi_reg   <= sr_reg[0];
                            sr_reg    <= sr_reg >> 1;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tck_fall) begin
                        if (bit_idx_reg == len_reg - LEN_W'(1)) begin
                            sdr_reg   <= 1'b0;
                            tdi_reg   <= 1'b0;
                            udr_reg   <= 1'b1;
                            state_reg <= ST_UDR;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + LEN_W'(1);
                            tdi_reg     <= sr_reg[0];
                            sr_reg      <= sr_reg >> 1;
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_fall) begin
                        udr_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // One clk after the final slot the response becomes visible
                    if (!rsp_valid_reg) begin
                        rsp_valid_reg <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Capture register: cleared at scan start, loaded at tck rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_reg <= '0;
        end else if (state_reg == ST_IDLE && pending_reg && tck_fall) begin
            cap_reg <= '0;
        end else if (tck_rise) begin
            if (state_reg == ST_UIR) begin
                cap_reg <= {{(DR_W-IR_W){1'b0}}, vji_ir_out};
            end else if (state_reg == ST_SHIFT) begin
                cap_reg[bit_idx_reg] <= vji_tdo;
            end
        end
    end

`ifdef SCAN_COUNT_EN
    logic [15:0] scan_count_reg;

    assign scan_count = scan_count_reg;

    // Counts completed DR scans (the UDR slot ending), saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_count_reg <= '0;
        end else if (state_reg == ST_UDR && tck_fall && scan_count_reg != 16'hFFFF) begin
            scan_count_reg <= scan_count_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audiosystem_debug_scan_master.sv
// Self-checking bench for audiosystem_debug_scan_master. The slave side is a
// loopback (tdo=tdi, ir_out=ir_in); expected responses are queued when each
// command is issued and compared when the response appears.
module tb_audiosystem_debug_scan_master;
    import audiosystem_debug_scan_pkg::*;

    localparam int TCK_DIV = 4;
    localparam int TB_DR_W = 38;
    localparam int TB_IR_W = 2;
    localparam int LEN_W   = 6;
    localparam int SLOT    = 2 * TCK_DIV;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_is_ir = 1'b0;
    logic [TB_IR_W-1:0] cmd_ir = '0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [TB_DR_W-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [TB_DR_W-1:0] rsp_data;
    logic               vji_tck, vji_tdi, vji_tdo;
    logic [TB_IR_W-1:0] vji_ir_in, vji_ir_out;
    logic               vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti;
`ifdef SCAN_COUNT_EN
    logic [15:0]        scan_count;
`endif

    always #5 clk = ~clk;

    assign vji_tdo    = vji_tdi;
    assign vji_ir_out = vji_ir_in;

    audiosystem_debug_scan_master #(
        .TCK_DIV(TCK_DIV), .DR_W(TB_DR_W), .IR_W(TB_IR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
        .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_uir(vji_uir), .vji_rti(vji_rti)
`ifdef SCAN_COUNT_EN
        , .scan_count(scan_count)
`endif
    );

    typedef struct {
        logic [TB_DR_W-1:0] data;
        int lat;
        int cdr;
        int sdr;
        int udr;
        int uir;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int cdr_n = 0, sdr_n = 0, udr_n = 0, uir_n = 0;
    int overlap_n = 0, order_n = 0;
    logic       prev_tck = 1'b0;
    logic [7:0] prev_vji = '0;

    // Advance one clk and sample 1 time unit after the edge
    task automatic step();
        logic [7:0] cur;
        logic fell;
        @(posedge clk);
        #1;
        cyc++;
        cur  = {vji_tdi, vji_ir_in, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti};
        fell = prev_tck && !vji_tck;
        if (fell && fall_cyc < 0) fall_cyc = cyc;
        if (!reset && cur != prev_vji && !fell) order_n++;
        if (int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_uir) > 1) overlap_n++;
        if ((vji_cdr | vji_sdr | vji_udr | vji_uir) && vji_rti) overlap_n++;
        cdr_n += int'(vji_cdr);
        sdr_n += int'(vji_sdr);
        udr_n += int'(vji_udr);
        uir_n += int'(vji_uir);
        prev_tck = vji_tck;
        prev_vji = cur;
    endtask

    task automatic send_cmd(input logic is_ir, input logic [TB_IR_W-1:0] ir,
                            input logic [LEN_W-1:0] len, input logic [TB_DR_W-1:0] data,
                            input bit push);
        int n = 0;
        int nl;
        exp_t e;
        logic [TB_DR_W-1:0] m;
        while (!cmd_ready && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_is_ir = is_ir;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        fall_cyc = -1;
        cdr_n = 0; sdr_n = 0; udr_n = 0; uir_n = 0;
        nl = (int'(len) > TB_DR_W) ? TB_DR_W : int'(len);
        m = '0;
        for (int i = 0; i < nl; i++) m[i] = 1'b1;
        e.data = '0;
        if (is_ir) e.data[TB_IR_W-1:0] = ir;
        else       e.data = data & m;
        e.lat = (is_ir ? 1 : nl + 2) * SLOT + 1;
        e.cdr = is_ir ? 0 : SLOT;
        e.sdr = is_ir ? 0 : nl * SLOT;
        e.udr = is_ir ? 0 : SLOT;
        e.uir = is_ir ? SLOT : 0;
        if (push) exp_q.push_back(e);
        $display("cmd: is_ir=%0b ir=%0d len=%0d data=%h", is_ir, ir, len, data);
    endtask

    // Wait for the response, compare against the scoreboard, optionally hold
    // rsp_ready low for 'hold' cycles, then complete the handshake
    task automatic collect(input string name, input int hold);
        int n = 0;
        int lat;
        int bad = 0;
        exp_t e;
        logic [TB_DR_W-1:0] held;
        while (!rsp_valid && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: queue depth 0 required >0", name);
            return;
        end
        e = exp_q.pop_front();
        lat = cyc - fall_cyc;
        $display("rsp %s: data=%h lat=%0d cdr=%0d sdr=%0d udr=%0d uir=%0d",
                 name, rsp_data, lat, cdr_n, sdr_n, udr_n, uir_n);
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d clk required %0d", name, lat, e.lat);
        end
        checks++;
        if (rsp_data !== e.data) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", name, rsp_data, e.data);
        end
        checks++;
        if (cdr_n != e.cdr || sdr_n != e.sdr || udr_n != e.udr || uir_n != e.uir) begin
            errors++;
            $display("FAIL %s_strobes: cdr/sdr/udr/uir=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     name, cdr_n, sdr_n, udr_n, uir_n, e.cdr, e.sdr, e.udr, e.uir);
        end
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) bad++;
        end
        if (hold > 0) begin
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_hold: %0d unstable cycles required 0", name, bad);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: rsp_valid=%b cmd_ready=%b required 0/1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        int toggles = 0;
        int last = -1;
        int bad_int = 0;
        int bad_idle = 0;
        logic t_prev;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b rsp_data=%h required 1/0/0",
                     cmd_ready, rsp_valid, rsp_data);
        end
        checks++;
        if ({vji_tck, vji_tdi, vji_ir_in, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti} !== 9'b0_0_00_0000_1) begin
            errors++;
            $display("FAIL reset_vji: tck,tdi,ir,cdr,sdr,udr,uir,rti=%b required 000000001",
                     {vji_tck, vji_tdi, vji_ir_in, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti});
        end
        reset = 1'b0;
        t_prev = vji_tck;
        for (int i = 0; i < 48; i++) begin
            step();
            if (vji_tck !== t_prev) begin
                if (last >= 0 && cyc - last != TCK_DIV) bad_int++;
                last = cyc;
                toggles++;
            end
            t_prev = vji_tck;
            if (vji_cdr | vji_sdr | vji_udr | vji_uir | !vji_rti | !cmd_ready) bad_idle++;
        end
        $display("idle: toggles=%0d bad_intervals=%0d bad_idle=%0d", toggles, bad_int, bad_idle);
        checks++;
        if (toggles < 11 || bad_int != 0) begin
            errors++;
            $display("FAIL idle_tck: toggles=%0d bad_intervals=%0d required >=11/0", toggles, bad_int);
        end
        checks++;
        if (bad_idle != 0) begin
            errors++;
            $display("FAIL idle_strobes: bad cycles=%0d required 0", bad_idle);
        end
    endtask

    task automatic test_ir_load();
        send_cmd(1'b1, IR_BREAK, '0, '0, 1'b1);
        collect("ir_break", 0);
        checks++;
        if (vji_ir_in !== 2'b10) begin
            errors++;
            $display("FAIL ir_in_break: got %b required 10", vji_ir_in);
        end
        send_cmd(1'b1, 2'b01, 6'd5, 38'h3F_FFFF_FFFF, 1'b1);
        collect("ir_trace", 0);
    endtask

    task automatic test_dr_scan();
        logic [TB_DR_W-1:0] d;
        send_cmd(1'b0, 2'b11, 6'd38, 38'h2A_5A5A_5A5A, 1'b1);
        collect("dr38", 0);
        d = TB_DR_W'({$urandom(), $urandom()});
        send_cmd(1'b0, 2'b00, 6'd13, d, 1'b1);
        collect("dr13", 0);
        checks++;
        if (vji_ir_in !== 2'b01) begin
            errors++;
            $display("FAIL ir_in_hold: got %b required 01", vji_ir_in);
        end
    endtask

    task automatic test_len_edges();
        send_cmd(1'b0, 2'b00, 6'd0, 38'h3F_FFFF_FFFF, 1'b1);
        collect("dr_len0", 0);
        send_cmd(1'b0, 2'b00, 6'd50, 38'h15_0F0F_3C3C, 1'b1);
        collect("dr_len50", 0);
        send_cmd(1'b0, 2'b00, 6'd1, 38'h3F_FFFF_FFFF, 1'b1);
        collect("dr_len1", 0);
    endtask

    task automatic test_back_pressure();
        send_cmd(1'b0, 2'b00, 6'd7, 38'h00_0000_005B, 1'b1);
        // Second command offered throughout the stall
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd9;
        cmd_data  = 38'h00_0000_01A5;
        collect("bp_first", 100);
        send_cmd(1'b0, 2'b00, 6'd9, 38'h00_0000_01A5, 1'b1);
        collect("bp_second", 0);
    endtask

    task automatic test_reset_mid_shift();
        int n = 0;
        int late = 0;
        send_cmd(1'b0, 2'b00, 6'd38, 38'h25_A5A5_A5A5, 1'b0);
        while (sdr_n < 10 * SLOT + 2 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (sdr_n < 10 * SLOT + 2) begin
            errors++;
            $display("FAIL midshift_reach: sdr cycles=%0d required %0d", sdr_n, 10 * SLOT + 2);
        end
        reset = 1'b1;
        step();
        $display("reset mid-shift: tck=%b rti=%b strobes=%b rsp_valid=%b",
                 vji_tck, vji_rti, {vji_cdr, vji_sdr, vji_udr, vji_uir}, rsp_valid);
        checks++;
        if ({vji_tck, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti, rsp_valid} !== 7'b0_0000_1_0) begin
            errors++;
            $display("FAIL midshift_reset: tck,cdr,sdr,udr,uir,rti,rsp_valid=%b required 0000010",
                     {vji_tck, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti, rsp_valid});
        end
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rsp_valid !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL midshift_no_rsp: rsp_valid cycles=%0d required 0", late);
        end
        send_cmd(1'b0, 2'b00, 6'd20, 38'h00_000C_3A5F, 1'b1);
        collect("after_reset", 0);
`ifdef SCAN_COUNT_EN
        checks++;
        if (scan_count !== 16'd1) begin
            errors++;
            $display("FAIL scan_count: got %0d required 1", scan_count);
        end
`endif
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_n != 0) begin
            errors++;
            $display("FAIL strobe_overlap: cycles=%0d required 0", overlap_n);
        end
        checks++;
        if (order_n != 0) begin
            errors++;
            $display("FAIL change_off_fall: cycles=%0d required 0", order_n);
        end
    endtask

    initial begin
        test_reset();
        test_ir_load();
        test_dr_scan();
        test_len_edges();
        test_back_pressure();
        test_reset_mid_shift();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
